fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: program counter, PC+4 incrementer, branch/jump redirect mux and the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and directly consumes that unit's Block_PC_Write and Block_IF_ID_Write. It also takes redirects from the ID and EX stages and supplies the fetched instruction plus PC+4 to decode. A saturating stall counter provides load-use stall statistics.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of stall counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Block_PC_Write  in  1  hold PC (from hazard detection unit)
- Block_IF_ID_Write  in  1  hold IF/ID register (from hazard detection unit)
- Branch_Taken  in  1  branch resolved taken (EX stage)
- Branch_Target  in  32  branch destination
- Jump  in  1  jump decoded (ID stage)
- Jump_Target  in  32  jump destination
- Instr_Data  in  32  instruction word from combinational instruction memory
- Instr_Addr  out  32  current PC, drives instruction memory
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PC_Plus4  out  32  registered PC+4
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- Stall_Count  out  CNT_WIDTH  cycles PC was held by hazard unit

## Operation
- Reset (reset=0, asynchronous): PC=RESET_PC; IF_ID_Instr=0; IF_ID_PC_Plus4=0; IF_ID_Valid=0; Stall_Count=0. Instr_Addr follows PC, so it reads RESET_PC during reset.
- Next-PC priority, highest first:
  - Branch_Taken -> {Branch_Target[31:2],2'b00}.
  - Jump -> {Jump_Target[31:2],2'b00}.
  - Block_PC_Write -> PC holds.
  - Otherwise -> PC+4.
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- Redirect means Branch_Taken or Jump. A redirect overrides both block inputs, because the stalled instruction is on the wrong path.
- IF/ID update rules:
  - Redirect: flush. Instr=32'h0000_0000 (NOP), PC_Plus4=0, Valid=0.
  - Else if Block_IF_ID_Write: all IF/ID fields hold.
  - Else: load Instr=Instr_Data, PC_Plus4=PC+4, Valid=1.
- The two block inputs are acted on independently.
  - Block_IF_ID_Write=1 with Block_PC_Write=0 advances the PC while IF/ID holds. The fetched word is dropped. The hazard unit never drives this combination; no protection is added.
  - Block_PC_Write=1 with Block_IF_ID_Write=0 reloads IF/ID with the same instruction.
- Branch_Taken and Jump both high: the branch wins, since it belongs to the older instruction. The stage flushes once.
- Stall_Count increments by 1 on each edge where Block_PC_Write=1 and no redirect is present. It saturates at all-ones and does not wrap.

## Timing
- Instr_Addr is combinational from the PC register, with zero latency.
- Instruction memory is combinational. Instr_Data is sampled at the same edge that updates the PC.
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect timing:
  - The redirect input at edge N loads the target PC at N.
  - The target instruction appears in IF/ID at edge N+1.
  - IF/ID shows a bubble for exactly the cycle after N.
- Stall timing: the hazard unit's combinational blocks sampled at edge N freeze PC and IF/ID at N. Normal flow resumes at the first edge with blocks deasserted.
- Reset deassertion: the first rising edge after reset=1 captures the RESET_PC instruction into IF/ID and moves the PC to RESET_PC+4.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. It discards any pending stall or redirect.

## Test plan
- Sequential fetch: release reset, ROM[RESET_PC+4k]=k+1, 4 edges -> IF_ID_Instr 1,2,3,4; IF_ID_PC_Plus4 32'h0040_0004..0040_0010; Valid=1; Stall_Count=0.
- Load-use stall: both blocks=1 for 2 edges at PC=32'h0040_0008 -> PC and IF/ID unchanged for 2 cycles; Stall_Count=2; PC then advances to 32'h0040_000C.
- Branch during stall: blocks=1 with Branch_Taken=1, Branch_Target=32'h0040_0103 -> PC=32'h0040_0100 (low bits cleared); IF_ID_Valid=0, Instr=0; Stall_Count unchanged; next edge Valid=1 with ROM[0x0040_0100].
- Simultaneous Jump and Branch_Taken: Jump_Target=32'h0040_0200, Branch_Target=32'h0040_0300 -> PC=32'h0040_0300; single bubble.
- Async reset mid-stall: blocks=1 and Stall_Count=5, pull reset low between edges -> all outputs reset values immediately; Instr_Addr=RESET_PC.
- Saturation and wrap: CNT_WIDTH=4, hold Block_PC_Write 20 cycles -> Stall_Count sticks at 15. Force PC=32'hFFFF_FFFC and advance one edge -> PC=0.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, PC+4 incrementer, branch/jump redirect
// mux, IF/ID pipeline register and a saturating hazard-stall counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Block_PC_Write,
    input  logic                 Block_IF_ID_Write,
    input  logic                 Branch_Taken,
    input  logic [31:0]          Branch_Target,
    input  logic                 Jump,
    input  logic [31:0]          Jump_Target,
    input  logic [31:0]          Instr_Data,
    output logic [31:0]          Instr_Addr,
    output logic [31:0]          IF_ID_Instr,
    output logic [31:0]          IF_ID_PC_Plus4,
    output logic                 IF_ID_Valid,
    output logic [CNT_WIDTH-1:0] Stall_Count
);

    logic [31:0]          r_pc;
    logic [31:0]          r_if_id_instr;
    logic [31:0]          r_if_id_pc_plus4;
    logic                 r_if_id_valid;
    logic [CNT_WIDTH-1:0] r_stall_count;

    logic [31:0]          w_pc_plus4;
    logic [31:0]          w_next_pc;
    logic                 w_redirect;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = Branch_Taken | Jump;

    // Branch beats jump: the branch in EX belongs to the older instruction.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next_pc and no latch is inferred.
        w_next_pc = w_pc_plus4;
        if (Branch_Taken) begin
            w_next_pc = {Branch_Target[31:2], 2'b00};
        end else if (Jump) begin
            w_next_pc = {Jump_Target[31:2], 2'b00};
        end else if (Block_PC_Write) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_pc <= w_next_pc;
        end
    end

    // A redirect flushes the wrong-path fetch even while the hazard unit is holding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_id_instr    <= 32'h0000_0000;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
        end else if (w_redirect) begin
            r_if_id_instr    <= 32'h0000_0000;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
        end else if (!Block_IF_ID_Write) begin
            r_if_id_instr    <= Instr_Data;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (Block_PC_Write && !w_redirect && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign Instr_Addr     = r_pc;
    assign IF_ID_Instr    = r_if_id_instr;
    assign IF_ID_PC_Plus4 = r_if_id_pc_plus4;
    assign IF_ID_Valid    = r_if_id_valid;
    assign Stall_Count    = r_stall_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, redirects, async reset,
// counter saturation (narrow instance) and PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        Block_PC_Write;
    logic        Block_IF_ID_Write;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [31:0] Jump_Target;

    logic [31:0] w_instr_data;
    logic [31:0] w_instr_addr;
    logic [31:0] w_if_id_instr;
    logic [31:0] w_if_id_pc_plus4;
    logic        w_if_id_valid;
    logic [15:0] w_stall_count;

    logic [31:0] w_instr_data_n;
    logic [31:0] w_instr_addr_n;
    logic [31:0] w_if_id_instr_n;
    logic [31:0] w_if_id_pc_plus4_n;
    logic        w_if_id_valid_n;
    logic [3:0]  w_stall_count_n;

    int n_checks = 0;
    int n_fail   = 0;

    // ROM contents: word k past RESET_PC holds k+1.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RESET_PC;
        return (off >> 2) + 32'd1;
    endfunction

    assign w_instr_data   = rom(w_instr_addr);
    assign w_instr_data_n = rom(w_instr_addr_n);

    fetch_stage #(.RESET_PC(RESET_PC), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .Block_PC_Write    (Block_PC_Write),
        .Block_IF_ID_Write (Block_IF_ID_Write),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Jump              (Jump),
        .Jump_Target       (Jump_Target),
        .Instr_Data        (w_instr_data),
        .Instr_Addr        (w_instr_addr),
        .IF_ID_Instr       (w_if_id_instr),
        .IF_ID_PC_Plus4    (w_if_id_pc_plus4),
        .IF_ID_Valid       (w_if_id_valid),
        .Stall_Count       (w_stall_count)
    );

    fetch_stage #(.RESET_PC(RESET_PC), .CNT_WIDTH(4)) dut_narrow (
        .clk               (clk),
        .reset             (reset),
        .Block_PC_Write    (Block_PC_Write),
        .Block_IF_ID_Write (Block_IF_ID_Write),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Jump              (Jump),
        .Jump_Target       (Jump_Target),
        .Instr_Data        (w_instr_data_n),
        .Instr_Addr        (w_instr_addr_n),
        .IF_ID_Instr       (w_if_id_instr_n),
        .IF_ID_PC_Plus4    (w_if_id_pc_plus4_n),
        .IF_ID_Valid       (w_if_id_valid_n),
        .Stall_Count       (w_stall_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] plus4, input logic valid);
        check({tag, ".pc"},    w_instr_addr, pc);
        check({tag, ".instr"}, w_if_id_instr, instr);
        check({tag, ".plus4"}, w_if_id_pc_plus4, plus4);
        check({tag, ".valid"}, {31'd0, w_if_id_valid}, {31'd0, valid});
    endtask

    task automatic set_in(input logic bpc, input logic bif, input logic br, input logic [31:0] bt,
                          input logic jp, input logic [31:0] jt);
        Block_PC_Write    = bpc;
        Block_IF_ID_Write = bif;
        Branch_Taken      = br;
        Branch_Target     = bt;
        Jump              = jp;
        Jump_Target       = jt;
    endtask

    initial begin
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        #12;
        check_ifid("reset", RESET_PC, 32'd0, 32'd0, 1'b0);
        check("reset.cnt", {16'd0, w_stall_count}, 32'd0);

        // Sequential fetch: four edges.
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_ifid($sformatf("seq%0d", k), RESET_PC + 32'(4 * k), 32'(k),
                       RESET_PC + 32'(4 * k), 1'b1);
        end
        check("seq.cnt", {16'd0, w_stall_count}, 32'd0);

        // Restart and stall at PC 0x0040_0008.
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        step();
        step();
        check_ifid("pre_stall", 32'h0040_0008, 32'd2, 32'h0040_0008, 1'b1);
        set_in(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check_ifid($sformatf("stall%0d", k), 32'h0040_0008, 32'd2, 32'h0040_0008, 1'b1);
        end
        check("stall.cnt", {16'd0, w_stall_count}, 32'd2);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("resume", 32'h0040_000C, 32'd3, 32'h0040_000C, 1'b1);

        // Branch during stall: low target bits cleared, flush, counter held.
        set_in(1'b1, 1'b1, 1'b1, 32'h0040_0103, 1'b0, 32'd0);
        step();
        check_ifid("br_stall", 32'h0040_0100, 32'd0, 32'd0, 1'b0);
        check("br_stall.cnt", {16'd0, w_stall_count}, 32'd2);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("br_target", 32'h0040_0104, 32'h0000_0041, 32'h0040_0104, 1'b1);

        // Branch and jump together: branch wins, one bubble.
        set_in(1'b0, 1'b0, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
        step();
        check_ifid("br_jmp", 32'h0040_0300, 32'd0, 32'd0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("br_jmp_tgt", 32'h0040_0304, 32'h0000_00C1, 32'h0040_0304, 1'b1);

        // Stall three more edges to reach count 5, then reset between edges.
        set_in(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        step();
        step();
        check("pre_rst.cnt", {16'd0, w_stall_count}, 32'd5);
        #2 reset = 1'b0;
        #1;
        check_ifid("async_rst", RESET_PC, 32'd0, 32'd0, 1'b0);
        check("async_rst.cnt", {16'd0, w_stall_count}, 32'd0);

        // Saturation: both instances stalled 20 edges from a fresh reset.
        reset = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("sat.narrow", {28'd0, w_stall_count_n}, 32'd15);
        check("sat.wide",   {16'd0, w_stall_count},   32'd20);
        check("sat.pc",     w_instr_addr, RESET_PC);

        // PC wrap: jump to the top word, then advance once.
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
        step();
        check_ifid("jmp_top", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("wrap", 32'h0000_0000, 32'h3FF0_0000, 32'h0000_0000, 1'b1);

        // PC held but IF/ID written: same instruction reloaded; counter advances.
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("pc_hold_only", 32'h0000_0000, 32'h3FF0_0001, 32'h0000_0004, 1'b1);
        check("pc_hold_only.cnt", {16'd0, w_stall_count}, 32'd21);

        // IF/ID held but PC advancing: fetched word dropped.
        set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_ifid("ifid_hold_only", 32'h0000_0004, 32'h3FF0_0001, 32'h0000_0004, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
